// File: rtl/latch_write_arbiter.sv
// rtl/latch_write_arbiter.sv - round-robin write arbiter/sequencer for a level-sensitive latch bank
// Optional LATCH_ARB_FIXED_PRI_EN: fixed lowest-index-wins priority instead of round-robin.
module latch_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*WIDTH-1:0]       wdata,
  output logic [N_REQ-1:0]             ack,
  output logic                         le,
  output logic [WIDTH-1:0]             ld,
  output logic [$clog2(N_REQ)-1:0]     gnt_id,
  output logic                         busy
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_OPEN  = 3'd2,
    S_CLOSE = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               le_q, le_d;
  logic [WIDTH-1:0]   ld_q, ld_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [GW-1:0]      win;
  logic               found;
  int                 idx;

`ifndef LATCH_ARB_FIXED_PRI_EN
  logic [GW-1:0]      ptr_q, ptr_d;
`endif

  // Winner search: first requester at or after the priority base, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef LATCH_ARB_FIXED_PRI_EN
      idx = k;
`else
      idx = (int'(ptr_q) + k) % N_REQ;
`endif
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    gnt_d   = gnt_q;
`ifndef LATCH_ARB_FIXED_PRI_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_SETUP;
          ld_d    = wdata[win*WIDTH +: WIDTH];
          gnt_d   = win;
        end
      end
      S_SETUP: state_d = S_OPEN;
      S_OPEN: begin
        state_d = S_CLOSE;
        cnt_d   = CW'(SETTLE - 1);
      end
      S_CLOSE: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
`ifndef LATCH_ARB_FIXED_PRI_EN
        ptr_d   = (int'(gnt_q) == N_REQ - 1) ? '0 : gnt_q + GW'(1);
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered decodes of the next state, so they align with the state register.
    le_d   = (state_d == S_OPEN);
    busy_d = (state_d != S_IDLE);
    ack_d  = '0;
    if (state_d == S_ACK) begin
      ack_d[gnt_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      le_q    <= 1'b0;
      ld_q    <= '0;
      ack_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
`ifndef LATCH_ARB_FIXED_PRI_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      le_q    <= le_d;
      ld_q    <= ld_d;
      ack_q   <= ack_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
`ifndef LATCH_ARB_FIXED_PRI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign le     = le_q;
  assign ld     = ld_q;
  assign ack    = ack_q;
  assign gnt_id = gnt_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb/tb_latch_write_arbiter.sv - directed plus randomized bench for latch_write_arbiter
// Reference model tracks each transaction by its age in cycles since grant.
module tb_latch_write_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int S    = 2;
  localparam int GW   = $clog2(N);
  localparam int LAST = 3 + S;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   wdata;
  logic [N-1:0]     ack;
  logic             le;
  logic [W-1:0]     ld;
  logic [GW-1:0]    gnt_id;
  logic             busy;

  latch_write_arbiter #(.N_REQ(N), .WIDTH(W), .SETTLE(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .ack    (ack),
    .le     (le),
    .ld     (ld),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          m_age = 0;
  int          m_gnt = 0;
  int          m_ptr = 0;
  logic [W-1:0] m_ld = '0;
  bit          auto_drop = 1'b1;
  int          grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    int base;
`ifdef LATCH_ARB_FIXED_PRI_EN
    base = 0;
`else
    base = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  // Advance the model over one rising edge, then compare outputs at the falling edge.
  task automatic cycle();
    int w;
    logic [N-1:0] e_ack;
    if (rst) begin
      m_age = 0; m_gnt = 0; m_ptr = 0; m_ld = '0;
    end else if (m_age == 0) begin
      w = pick(req);
      if (w >= 0) begin
        m_gnt = w;
        m_ld  = wdata[w*W +: W];
        m_age = 1;
      end
    end else if (m_age == LAST) begin
      m_age = 0;
      m_ptr = (m_gnt + 1) % N;
    end else begin
      m_age++;
    end
    @(posedge clk);
    @(negedge clk);
    e_ack = (m_age == LAST) ? N'(1 << m_gnt) : '0;
    chk("le",     32'(le),     32'(m_age == 2));
    chk("busy",   32'(busy),   32'(m_age != 0));
    chk("ack",    32'(ack),    32'(e_ack));
    chk("ld",     32'(ld),     32'(m_ld));
    chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
    for (int i = 0; i < N; i++) if (ack[i]) grants.push_back(i);
    if (auto_drop) req = req & ~ack;
  endtask

  task automatic collect(input int n, input int budget);
    int c;
    c = 0;
    while (grants.size() < n && c < budget) begin
      cycle();
      c++;
    end
    chk("collect_done", 32'(grants.size()), 32'(n));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    rst = 1'b0;
  endtask

  task automatic check_order(input string tag, input int e0, input int e1, input int e2, input int e3, input int n);
    int exp_q[4];
    exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
    chk({tag, "_count"}, 32'(grants.size()), 32'(n));
    for (int i = 0; i < n && i < grants.size(); i++) chk(tag, 32'(grants[i]), 32'(exp_q[i]));
  endtask

  initial begin
    rst = 1'b1; req = '0; wdata = '0;

    // Reset values
    do_reset(3);

    // Single write from requester 0
    wdata = {$urandom(), 8'hA5};
    req = 4'b0001;
    grants.delete();
    collect(1, 12);
    check_order("single", 0, 0, 0, 0, 1);
    chk("single_ld", 32'(ld), 32'h0000_00A5);

    // Contention from reset: all four requesters held
    do_reset(1);
    wdata = {$urandom(), $urandom()};
    req = 4'b1111;
    grants.delete();
    collect(4, 40);
    check_order("contend", 0, 1, 2, 3, 4);

    // Wrap-around after a grant to 2
    do_reset(1);
    req = 4'b0100;
    grants.delete();
    collect(1, 12);
    req = 4'b1011;
    grants.delete();
    collect(3, 30);
`ifdef LATCH_ARB_FIXED_PRI_EN
    check_order("wrap", 0, 1, 3, 0, 3);
`else
    check_order("wrap", 3, 0, 1, 0, 3);
`endif

    // Early drop: one-cycle pulse on req[1]
    for (int i = 0; i < 10 && m_age != 0; i++) cycle();
    chk("idle_before_drop", 32'(m_age), 32'd0);
    wdata = {$urandom(), $urandom()};
    req = 4'b0010;
    cycle();
    req = '0;
    wdata = ~wdata;
    grants.delete();
    for (int i = 0; i < 6; i++) cycle();
    check_order("early_drop", 1, 0, 0, 0, 1);

    // Reset asserted while the latch enable is open
    req = 4'b0001;
    cycle();
    cycle();
    chk("mid_open_le", 32'(le), 32'd1);
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b0;
    grants.delete();
    for (int i = 0; i < 10; i++) cycle();
    chk("no_ack_after_reset", 32'(grants.size()), 32'd0);

`ifdef LATCH_ARB_FIXED_PRI_EN
    // Fixed priority: requester 1 always beats 3
    auto_drop = 1'b0;
    req = 4'b1010;
    grants.delete();
    collect(5, 40);
    for (int i = 0; i < grants.size(); i++) chk("fixed_pri", 32'(grants[i]), 32'd1);
    req = '0;
    auto_drop = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
`endif

    // Randomized traffic with occasional resets and withdrawn requests
    for (int c = 0; c < 3000; c++) begin
      wdata = {$urandom(), $urandom()};
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
